multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit.
// A Moore FSM walks each instruction through fetch, decode and its execute and
// write-back phases. Memory phases wait for mem_ready. Reset blanks every write enable.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDist,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ANDIEX = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_r;
    state_t next_state;

    // Write enables before the reset override.
    logic irwrite_raw;
    logic pcwrite_raw;
    logic memwrite_raw;
    logic regwrite_raw;
    logic illegal_raw;

    assign state = state_r;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state;
        end
    end

    // Next-state selection and per-state control outputs (Moore, with ready/Zero qualified enables).
    always_comb begin
        next_state   = state_r;
        IorD         = 1'b0;
        RegDist      = 1'b0;
        MemToReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSrc        = 2'b00;
        ALUOp        = 2'b00;
        irwrite_raw  = 1'b0;
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        case (state_r)
            S_FETCH: begin
                ALUSrcB     = 2'b01;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                ALUSrcB = 2'b11;
                case (OPCode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYP:      next_state = S_RTEX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_ANDI:      next_state = S_ANDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state  = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (OPCode == OP_LW) begin
                    next_state = S_MEMRD;
                end else begin
                    next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMWB: begin
                MemToReg     = 1'b1;
                regwrite_raw = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEMWR: begin
                // MemWrite is held for the whole access, stalls included.
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_MEMWR;
                end
            end
            S_RTEX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegDist      = 1'b1;
                regwrite_raw = 1'b1;
                next_state   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSrc       = 2'b01;
                pcwrite_raw = Zero;
                next_state  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_IMMWB;
            end
            S_ANDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_raw = 1'b1;
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                PCSrc       = 2'b10;
                pcwrite_raw = 1'b1;
                next_state  = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset overrides every write enable so an interrupted instruction leaves no side effects.
    always_comb begin
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end else begin
            IRWrite    = irwrite_raw;
            PCWrite    = pcwrite_raw;
            MemWrite   = memwrite_raw;
            RegWrite   = regwrite_raw;
            illegal_op = illegal_raw;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller.
// Instructions are planned as phase sequences taken from the instruction rules, and the
// expected output vector of every cycle is queued as it is driven. A negedge monitor compares
// the queued vectors with the DUT and also checks per-instruction write-enable totals.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPCode;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, IRWrite, PCWrite, MemWrite, RegWrite, RegDist, MemToReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic       illegal_op;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .OPCode(OPCode), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDist(RegDist), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [18:0] exp;
        logic        last;     // final cycle of an instruction
        logic        chk;      // instruction ran to completion, totals are meaningful
        int          exp_regw; // RegWrite cycles expected over the instruction
        int          exp_memw; // MemWrite cycles expected over the instruction
    } cyc_t;

    cyc_t plan[$];
    cyc_t sbq[$];

    int checks = 0;
    int errors = 0;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b001100) ||
               (op == 6'b000010);
    endfunction

    // Expected output vector for one cycle, from the per-state output table.
    function automatic logic [18:0] model_out(input logic [3:0] st, input logic mr,
                                              input logic z, input logic rst,
                                              input logic [5:0] op);
        logic iord, irw, pcw, memw, regw, rd, m2r, srca, ill;
        logic [1:0] srcb, pcsrc, aluop;
        {iord, irw, pcw, memw, regw, rd, m2r, srca, ill} = 9'd0;
        srcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
        case (st)
            4'd0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin srcb = 2'b11; ill = !is_legal(op); end
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin iord = 1'b1; end
            4'd4:  begin m2r = 1'b1; regw = 1'b1; end
            4'd5:  begin iord = 1'b1; memw = 1'b1; end
            4'd6:  begin srca = 1'b1; aluop = 2'b10; end
            4'd7:  begin rd = 1'b1; regw = 1'b1; end
            4'd8:  begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pcw = z; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; end
            4'd10: begin srca = 1'b1; srcb = 2'b10; aluop = 2'b11; end
            4'd11: begin regw = 1'b1; end
            4'd12: begin pcsrc = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            {irw, pcw, memw, regw, ill} = 5'd0;
        end
        return {st, iord, irw, pcw, memw, regw, rd, m2r, srca, srcb, pcsrc, aluop, ill};
    endfunction

    // Plan one instruction: fs fetch stalls, ms memory stalls, branch flag z,
    // optional reset on cycle index rst_at (-1 = none).
    task automatic build_instr(input logic [5:0] op, input int fs, input int ms,
                               input logic z, input int rst_at);
        int   sts[$];
        logic mrs[$];
        int   regw_n;
        int   memw_n;
        cyc_t c;
        for (int i = 0; i < fs; i++) begin sts.push_back(0); mrs.push_back(1'b0); end
        sts.push_back(0); mrs.push_back(1'b1);
        sts.push_back(1); mrs.push_back(1'($urandom));
        regw_n = 0;
        memw_n = 0;
        case (op)
            6'b100011: begin
                sts.push_back(2); mrs.push_back(1'($urandom));
                for (int i = 0; i < ms; i++) begin sts.push_back(3); mrs.push_back(1'b0); end
                sts.push_back(3); mrs.push_back(1'b1);
                sts.push_back(4); mrs.push_back(1'($urandom));
                regw_n = 1;
            end
            6'b101011: begin
                sts.push_back(2); mrs.push_back(1'($urandom));
                for (int i = 0; i < ms; i++) begin sts.push_back(5); mrs.push_back(1'b0); end
                sts.push_back(5); mrs.push_back(1'b1);
                memw_n = ms + 1;
            end
            6'b000000: begin
                sts.push_back(6); mrs.push_back(1'($urandom));
                sts.push_back(7); mrs.push_back(1'($urandom));
                regw_n = 1;
            end
            6'b000100: begin sts.push_back(8); mrs.push_back(1'($urandom)); end
            6'b001000: begin
                sts.push_back(9);  mrs.push_back(1'($urandom));
                sts.push_back(11); mrs.push_back(1'($urandom));
                regw_n = 1;
            end
            6'b001100: begin
                sts.push_back(10); mrs.push_back(1'($urandom));
                sts.push_back(11); mrs.push_back(1'($urandom));
                regw_n = 1;
            end
            6'b000010: begin sts.push_back(12); mrs.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            c.rst = (i == rst_at);
            // Opcode is meaningful only in DECODE and MEMADR; elsewhere it is noise.
            c.op  = (sts[i] == 1 || sts[i] == 2) ? op : 6'($urandom);
            c.z   = (sts[i] == 8) ? z : 1'($urandom);
            c.mr  = mrs[i];
            c.exp = model_out(4'(sts[i]), c.mr, c.z, c.rst, c.op);
            c.last = c.rst || (i == sts.size() - 1);
            c.chk  = !c.rst;
            c.exp_regw = regw_n;
            c.exp_memw = memw_n;
            plan.push_back(c);
            if (c.rst) break;
        end
    endtask

    // Monitor: pop one expected vector per cycle and compare with the DUT.
    int n_fetch_pcw = 0, n_irw = 0, n_regw = 0, n_memw = 0, n_instr = 0;
    always @(negedge clk) begin
        cyc_t e;
        logic [18:0] act;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            act = {state, IorD, IRWrite, PCWrite, MemWrite, RegWrite, RegDist, MemToReg,
                   ALUSrcA, ALUSrcB, PCSrc, ALUOp, illegal_op};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t instr=%0d got=%h expected=%h", $time,
                         n_instr, act, e.exp);
            end
            if (PCWrite === 1'b1 && state == 4'd0) n_fetch_pcw++;
            if (IRWrite === 1'b1) n_irw++;
            if (RegWrite === 1'b1) n_regw++;
            if (MemWrite === 1'b1) n_memw++;
            if (e.last) begin
                if (e.chk) begin
                    checks++;
                    if (n_fetch_pcw != 1 || n_irw != 1) begin
                        errors++;
                        $display("FAIL fetch_writes instr=%0d pcw=%0d irw=%0d expected 1 and 1",
                                 n_instr, n_fetch_pcw, n_irw);
                    end
                    checks++;
                    if (n_regw != e.exp_regw || n_memw != e.exp_memw) begin
                        errors++;
                        $display("FAIL data_writes instr=%0d regw=%0d memw=%0d expected %0d and %0d",
                                 n_instr, n_regw, n_memw, e.exp_regw, e.exp_memw);
                    end
                end
                n_fetch_pcw = 0; n_irw = 0; n_regw = 0; n_memw = 0;
                n_instr++;
            end
        end
    end

    // Stimulus driver: apply planned inputs after each rising edge and queue expectations.
    initial begin
        cyc_t c;
        logic [5:0] legal_ops [7];
        logic [5:0] op;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b001100, 6'b000010};
        reset = 1'b1; OPCode = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        // Second reset cycle: already in FETCH, enables must stay low despite mem_ready.
        c.rst = 1'b1; c.op = 6'b100011; c.z = 1'b0; c.mr = 1'b1;
        c.exp = model_out(4'd0, 1'b1, 1'b0, 1'b1, 6'b100011);
        c.last = 1'b1; c.chk = 1'b0; c.exp_regw = 0; c.exp_memw = 0;
        plan.push_back(c);

        build_instr(6'b100011, 0, 0, 1'b0, -1);   // LW, no stalls
        build_instr(6'b101011, 0, 3, 1'b0, -1);   // SW, 3 stalls in MEMWR
        build_instr(6'b000100, 0, 0, 1'b1, -1);   // BEQ taken
        build_instr(6'b000100, 0, 0, 1'b0, -1);   // BEQ not taken
        build_instr(6'b111111, 0, 0, 1'b0, -1);   // illegal
        build_instr(6'b100011, 0, 2, 1'b0, 3);    // LW reset during MEMRD stall
        build_instr(6'b001000, 0, 0, 1'b0, -1);   // ADDI after reset
        build_instr(6'b000000, 0, 0, 1'b0, -1);   // R-type
        build_instr(6'b001100, 0, 0, 1'b0, -1);   // ANDI
        build_instr(6'b000010, 0, 0, 1'b0, -1);   // J
        build_instr(6'b001100, 2, 0, 1'b0, -1);   // ANDI with fetch stalls

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            build_instr(op, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                        ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                        1'($urandom),
                        ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : -1);
        end

        while (plan.size() > 0) begin
            c = plan.pop_front();
            reset = c.rst; OPCode = c.op; Zero = c.z; mem_ready = c.mr;
            sbq.push_back(c);
            @(posedge clk); #1;
        end
        reset = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t expected completion earlier", $time);
        $fatal(1);
    end

endmodule
